// File: rtl/jtag_debug_dispatch_mc_if.sv
// Signal bundle between the virtual-JTAG capture side and the multi-core debug dispatcher.
interface jtag_debug_dispatch_mc_if #(
    parameter int NUM_CORES = 7,
    parameter int SR_WIDTH  = 38,
    parameter int IR_WIDTH  = 2
);
    localparam int SEL_W = $clog2(NUM_CORES + 1);

    logic                 udr_tog;
    logic [SR_WIDTH-1:0]  sr;
    logic [IR_WIDTH-1:0]  ir_in;
    logic [SEL_W-1:0]     core_sel;
    logic [NUM_CORES-1:0] core_ready;
    logic                 err_clr;
    logic [SR_WIDTH-1:0]  jdo;
    logic [IR_WIDTH-1:0]  action_ir;
    logic [NUM_CORES-1:0] action_valid;
    logic                 busy;
    logic                 timeout_err;
    logic                 overrun_err;
    logic                 sel_err;
    logic [15:0]          cmd_count;

    modport master (
        output udr_tog, sr, ir_in, core_sel, core_ready, err_clr,
        input  jdo, action_ir, action_valid, busy, timeout_err, overrun_err, sel_err, cmd_count
    );

    modport slave (
        input  udr_tog, sr, ir_in, core_sel, core_ready, err_clr,
        output jdo, action_ir, action_valid, busy, timeout_err, overrun_err, sel_err, cmd_count
    );
endinterface

// File: rtl/jtag_debug_dispatch_mc.sv
// Synchronises TCK-domain update-DR toggles and dispatches the captured command
// to one core (or all in broadcast) under a per-core ready handshake with timeout.
module jtag_debug_dispatch_mc #(
    parameter int NUM_CORES   = 7,
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input logic clk,
    input logic reset_n,
    jtag_debug_dispatch_mc_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_CORES + 1);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int MASK_W = $clog2(SYNC_STAGES + 2);

    localparam logic [SEL_W-1:0]     BCAST     = '1;
    localparam logic [SEL_W-1:0]     LAST_CORE = SEL_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [MASK_W-1:0]    ARMED     = MASK_W'(SYNC_STAGES + 1);
    localparam logic [NUM_CORES-1:0] ONE_HOT0  = NUM_CORES'(1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [MASK_W-1:0]      arm_q, arm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
    logic [IR_WIDTH-1:0]    ir_q, ir_d;
    logic [NUM_CORES-1:0]   valid_q, valid_d;
    logic [15:0]            cmd_q, cmd_d;
    logic                   to_err_q, to_err_d;
    logic                   ov_err_q, ov_err_d;
    logic                   sel_err_q, sel_err_d;

    logic udr_pulse;
    logic sel_ok;
    logic to_set, ov_set, sel_set;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            dly_q     <= 1'b0;
            arm_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            jdo_q     <= '0;
            ir_q      <= '0;
            valid_q   <= '0;
            cmd_q     <= '0;
            to_err_q  <= 1'b0;
            ov_err_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            dly_q     <= dly_d;
            arm_q     <= arm_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            jdo_q     <= jdo_d;
            ir_q      <= ir_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            to_err_q  <= to_err_d;
            ov_err_q  <= ov_err_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.udr_tog};
        dly_d     = sync_q[SYNC_STAGES-1];
        arm_d     = (arm_q == ARMED) ? arm_q : arm_q + MASK_W'(1);
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        jdo_d     = jdo_q;
        ir_d      = ir_q;
        valid_d   = '0;
        cmd_d     = cmd_q;
        to_set    = 1'b0;
        ov_set    = 1'b0;
        sel_set   = 1'b0;

        // A toggle resting at 1 across reset would otherwise look like a fresh command.
        udr_pulse = (sync_q[SYNC_STAGES-1] ^ dly_q) && (arm_q == ARMED);
        sel_ok    = (bus.core_sel == BCAST) || (bus.core_sel <= LAST_CORE);

        if (state_q == ST_WAIT) begin
            if ((bus.core_ready & mask_q) == mask_q) begin
                valid_d = mask_q;
                cmd_d   = cmd_q + 16'd1;
                state_d = ST_IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                to_set  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A pulse coinciding with a WAIT exit is treated as arriving in IDLE.
        if (udr_pulse) begin
            if (state_d == ST_WAIT) begin
                ov_set = 1'b1;
            end else if (sel_ok) begin
                jdo_d   = bus.sr;
                ir_d    = bus.ir_in;
                mask_d  = (bus.core_sel == BCAST) ? '1 : (ONE_HOT0 << bus.core_sel);
                cnt_d   = '0;
                state_d = ST_WAIT;
            end else begin
                sel_set = 1'b1;
            end
        end

        to_err_d  = (to_err_q  & ~bus.err_clr) | to_set;
        ov_err_d  = (ov_err_q  & ~bus.err_clr) | ov_set;
        sel_err_d = (sel_err_q & ~bus.err_clr) | sel_set;
    end

    assign bus.jdo          = jdo_q;
    assign bus.action_ir    = ir_q;
    assign bus.action_valid = valid_q;
    assign bus.busy         = (state_q == ST_WAIT);
    assign bus.timeout_err  = to_err_q;
    assign bus.overrun_err  = ov_err_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.cmd_count    = cmd_q;
endmodule

// File: tb/tb_jtag_debug_dispatch_mc.sv
// Self-checking bench: vector table, hand-written corner sequences, then random
// traffic against a transaction-level reference model.
module tb_jtag_debug_dispatch_mc;
    localparam int S   = 2;
    localparam int TO  = 16;
    localparam int NC  = 7;
    localparam int NCB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    jtag_debug_dispatch_mc_if #(.NUM_CORES(NC),  .SR_WIDTH(38), .IR_WIDTH(2)) ifA ();
    jtag_debug_dispatch_mc_if #(.NUM_CORES(NCB), .SR_WIDTH(38), .IR_WIDTH(2)) ifB ();

    jtag_debug_dispatch_mc #(
        .NUM_CORES(NC), .SR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(S), .TIMEOUT(TO)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .bus(ifA)
    );

    jtag_debug_dispatch_mc #(
        .NUM_CORES(NCB), .SR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(S), .TIMEOUT(TO)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .bus(ifB)
    );

    typedef struct packed {
        logic [2:0]  sel;
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [6:0]  ready;
        logic [6:0]  expValid;
        logic [15:0] expCmd;
    } vec_t;

    typedef struct packed {
        int          at;
        logic [2:0]  sel;
        logic [1:0]  ir;
        logic [37:0] sr;
    } arr_t;

    vec_t vecs[6];
    int   vecCount  = 0;
    int   missCount = 0;

    // Reference model: pending command with an absolute timeout deadline, arrivals queued by edge.
    arr_t        arrQ[$];
    int          edgeNo;
    bit          mPending;
    int          mDeadline;
    logic [6:0]  mMask;
    logic [37:0] mJdo;
    logic [1:0]  mIr;
    logic [6:0]  mAv;
    logic [15:0] mCmd;
    bit          mTo, mOv, mSelE;
    int          gap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [1:0] ir,
                                 input logic [37:0] sr, input logic [6:0] ready);
        ifA.core_sel   = sel;
        ifA.ir_in      = ir;
        ifA.sr         = sr;
        ifA.core_ready = ready;
        ifA.udr_tog    = ~ifA.udr_tog;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        ifA.udr_tog = 1'b0; ifA.sr = '0; ifA.ir_in = '0; ifA.core_sel = '0;
        ifA.core_ready = '0; ifA.err_clr = 1'b0;
        ifB.udr_tog = 1'b0; ifB.sr = '0; ifB.ir_in = '0; ifB.core_sel = '0;
        ifB.core_ready = '0; ifB.err_clr = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic modelStep(input bit tog);
        arr_t a;
        bit   toSet, ovSet, selSet;
        toSet = 0; ovSet = 0; selSet = 0;
        edgeNo++;
        if (tog) arrQ.push_back('{at: edgeNo + S, sel: ifA.core_sel, ir: ifA.ir_in, sr: ifA.sr});
        mAv = '0;
        if (mPending) begin
            if ((ifA.core_ready & mMask) == mMask) begin
                mAv = mMask;
                mCmd = mCmd + 16'd1;
                mPending = 0;
            end else if (edgeNo == mDeadline) begin
                toSet = 1;
                mPending = 0;
            end
        end
        if (arrQ.size() != 0 && arrQ[0].at == edgeNo) begin
            a = arrQ.pop_front();
            if (edgeNo <= S + 1) begin
                // dropped while the synchroniser is still arming after reset
            end else if (mPending) begin
                ovSet = 1;
            end else if (a.sel == 3'd7 || int'(a.sel) < NC) begin
                mJdo = a.sr;
                mIr = a.ir;
                mMask = (a.sel == 3'd7) ? 7'h7F : (7'(1) << a.sel);
                mPending = 1;
                mDeadline = edgeNo + TO;
            end else begin
                selSet = 1;
            end
        end
        mTo   = (mTo   & ~ifA.err_clr) | toSet;
        mOv   = (mOv   & ~ifA.err_clr) | ovSet;
        mSelE = (mSelE & ~ifA.err_clr) | selSet;
    endtask

    task automatic driveRandom(output bit tog);
        logic [63:0] srTmp;
        tog = 0;
        if (gap == 0) begin
            srTmp = {$urandom(), $urandom()};
            ifA.sr       = srTmp[37:0];
            ifA.core_sel = 3'($urandom_range(0, 7));
            ifA.ir_in    = 2'($urandom_range(0, 3));
            ifA.udr_tog  = ~ifA.udr_tog;
            tog = 1;
            gap = $urandom_range(3, 12);
        end else begin
            gap--;
        end
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0:       ifA.core_ready = 7'h7F;
                1:       ifA.core_ready = 7'h00;
                default: ifA.core_ready = 7'($urandom());
            endcase
        end
        ifA.err_clr = ($urandom_range(0, 15) == 0);
    endtask

    task automatic compareModel();
        checkOutput("rand.jdo", ifA.jdo, mJdo);
        checkOutput("rand.valid", ifA.action_valid, mAv);
        checkOutput("rand.status",
                    {ifA.action_ir, ifA.busy, ifA.timeout_err, ifA.overrun_err, ifA.sel_err},
                    {mIr, mPending, mTo, mOv, mSelE});
        checkOutput("rand.cmd", ifA.cmd_count, mCmd);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stray;
        bit tog;

        vecs[0] = '{sel: 3'd3, ir: 2'd2, sr: 38'h2A_1234_5678, ready: 7'h7F, expValid: 7'h08, expCmd: 16'd1};
        vecs[1] = '{sel: 3'd0, ir: 2'd1, sr: 38'h00_0000_0001, ready: 7'h7F, expValid: 7'h01, expCmd: 16'd2};
        vecs[2] = '{sel: 3'd6, ir: 2'd3, sr: 38'h3F_FFFF_FFFF, ready: 7'h7F, expValid: 7'h40, expCmd: 16'd3};
        vecs[3] = '{sel: 3'd7, ir: 2'd0, sr: 38'h15_5555_5555, ready: 7'h7F, expValid: 7'h7F, expCmd: 16'd4};
        vecs[4] = '{sel: 3'd2, ir: 2'd1, sr: 38'h01_0203_0405, ready: 7'h04, expValid: 7'h04, expCmd: 16'd5};
        vecs[5] = '{sel: 3'd5, ir: 2'd2, sr: 38'h0A_BCDE_F012, ready: 7'h20, expValid: 7'h20, expCmd: 16'd6};

        doReset();
        tick();
        checkOutput("reset.jdo", ifA.jdo, 38'h0);
        checkOutput("reset.status",
                    {ifA.action_ir, ifA.action_valid, ifA.busy, ifA.timeout_err, ifA.overrun_err, ifA.sel_err},
                    '0);
        checkOutput("reset.cmd", ifA.cmd_count, 16'h0);
        repeat (4) tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].ir, vecs[i].sr, vecs[i].ready);
            repeat (S + 1) tick();
            checkOutput($sformatf("tbl%0d.busyLatched", i), ifA.busy, 1'b1);
            checkOutput($sformatf("tbl%0d.noEarlyStrobe", i), ifA.action_valid, 7'h0);
            tick();
            checkOutput($sformatf("tbl%0d.valid", i), ifA.action_valid, vecs[i].expValid);
            checkOutput($sformatf("tbl%0d.jdo", i), ifA.jdo, vecs[i].sr);
            checkOutput($sformatf("tbl%0d.ir", i), ifA.action_ir, vecs[i].ir);
            checkOutput($sformatf("tbl%0d.cmd", i), ifA.cmd_count, vecs[i].expCmd);
            checkOutput($sformatf("tbl%0d.busyDone", i), ifA.busy, 1'b0);
            tick();
            checkOutput($sformatf("tbl%0d.oneCycle", i), ifA.action_valid, 7'h0);
            tick();
        end

        $display("[TB] broadcast waiting on the last ready bit");
        applyStimulus(3'd7, 2'd1, 38'h12_3456_789A, 7'h7E);
        repeat (S + 1) tick();
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifA.action_valid != 7'h0) stray++;
        end
        checkOutput("bcast.noStrobe", stray, 0);
        checkOutput("bcast.busy", ifA.busy, 1'b1);
        ifA.core_ready = 7'h7F;
        tick();
        checkOutput("bcast.valid", ifA.action_valid, 7'h7F);
        checkOutput("bcast.cmd", ifA.cmd_count, 16'd7);
        tick();
        checkOutput("bcast.oneCycle", ifA.action_valid, 7'h0);

        $display("[TB] timeout with target never ready");
        applyStimulus(3'd1, 2'd0, 38'h00_DEAD_BEEF, 7'h00);
        repeat (S + 1) tick();
        repeat (TO - 1) tick();
        checkOutput("tmo.notYet", {ifA.timeout_err, ifA.busy}, 2'b01);
        tick();
        checkOutput("tmo.flagged", {ifA.timeout_err, ifA.busy}, 2'b10);
        checkOutput("tmo.noStrobe", ifA.action_valid, 7'h0);
        checkOutput("tmo.cmd", ifA.cmd_count, 16'd7);
        ifA.err_clr = 1'b1;
        tick();
        ifA.err_clr = 1'b0;
        checkOutput("tmo.cleared", ifA.timeout_err, 1'b0);

        $display("[TB] overrun while waiting");
        applyStimulus(3'd2, 2'd3, 38'h11_1111_1111, 7'h00);
        repeat (S + 1) tick();
        tick();
        applyStimulus(3'd4, 2'd0, 38'h22_2222_2222, 7'h00);
        repeat (S + 1) tick();
        checkOutput("ovr.flag", {ifA.overrun_err, ifA.busy}, 2'b11);
        ifA.core_ready = 7'h7F;
        tick();
        checkOutput("ovr.firstIssued", ifA.action_valid, 7'h04);
        checkOutput("ovr.jdo", ifA.jdo, 38'h11_1111_1111);
        checkOutput("ovr.ir", ifA.action_ir, 2'd3);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifA.action_valid != 7'h0 || ifA.busy) stray++;
        end
        checkOutput("ovr.secondDropped", stray, 0);
        checkOutput("ovr.cmd", ifA.cmd_count, 16'd8);

        $display("[TB] out-of-range select on the four-core instance");
        ifB.core_ready = 4'hF;
        ifB.core_sel   = 3'd5;
        ifB.udr_tog    = ~ifB.udr_tog;
        repeat (S + 1) tick();
        checkOutput("selB.flag", {ifB.sel_err, ifB.busy}, 2'b10);
        tick();
        checkOutput("selB.idle", {ifB.busy, ifB.action_valid}, 5'b0);
        ifB.core_sel = 3'd3;
        ifB.sr       = 38'h33_0000_0033;
        ifB.udr_tog  = ~ifB.udr_tog;
        repeat (S + 2) tick();
        checkOutput("selB.valid", ifB.action_valid, 4'h8);
        checkOutput("selB.cmd", {ifB.sel_err, ifB.cmd_count}, {1'b1, 16'd1});

        $display("[TB] reset mid-WAIT with toggle high");
        applyStimulus(3'd0, 2'd1, 38'h0F_0F0F_0F0F, 7'h00);
        repeat (S + 3) tick();
        checkOutput("rst.waiting", {ifA.udr_tog, ifA.busy}, 2'b11);
        reset_n = 1'b0;
        repeat (2) tick();
        checkOutput("rst.jdo", ifA.jdo, 38'h0);
        checkOutput("rst.status",
                    {ifA.action_ir, ifA.action_valid, ifA.busy, ifA.timeout_err, ifA.overrun_err, ifA.sel_err},
                    '0);
        checkOutput("rst.cmd", ifA.cmd_count, 16'h0);
        ifA.core_ready = 7'h7F;
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifA.action_valid != 7'h0 || ifA.busy || ifA.cmd_count != 16'h0) stray++;
        end
        checkOutput("rst.noSpurious", stray, 0);

        $display("[TB] random traffic against reference model");
        doReset();
        arrQ.delete();
        edgeNo = 0; mPending = 0; mDeadline = 0; mMask = '0; mJdo = '0; mIr = '0;
        mAv = '0; mCmd = '0; mTo = 0; mOv = 0; mSelE = 0;
        gap = 5;
        driveRandom(tog);
        modelStep(tog);
        for (int c = 0; c < 1500; c++) begin
            tick();
            compareModel();
            driveRandom(tog);
            modelStep(tog);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/jtag_debug_dispatch_mc.md
# jtag_debug_dispatch_mc

Clock-domain-side command dispatcher for the multi-core JTAG debug path. It receives update-DR events from one shared virtual-JTAG TCK block as an asynchronous toggle, synchronises them, and latches the shifted data word, IR and target-core select. It then issues a one-cycle action strobe to one core, or to all cores in broadcast, under a per-core ready handshake with timeout. It replaces the per-core sysclk capture block in the 7-core system and generalises it in core count, data width and IR width.

## Interface
- NUM_CORES, 7, number of debug targets (1..255)
- SR_WIDTH, 38, width of the captured shift-register word
- IR_WIDTH, 2, width of the virtual-JTAG instruction
- SYNC_STAGES, 2, synchroniser depth S for the update toggle (≥2)
- TIMEOUT, 1024, maximum cycles to wait for target ready; 0 means wait forever
- SEL_W (derived) = clog2(NUM_CORES+1); broadcast select value BCAST = all ones of SEL_W
---
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous and active-low
- udr_tog  in  1  update-DR toggle from the TCK domain (asynchronous)
- sr  in  SR_WIDTH  shift-register word; stable for ≥S+1 cycles after udr_tog changes
- ir_in  in  IR_WIDTH  instruction captured with sr; same stability rule
- core_sel  in  SEL_W  target core index, or BCAST; same stability rule
- core_ready  in  NUM_CORES  per-core "can accept action" flag
- err_clr  in  1  clears all sticky error flags
- jdo  out  SR_WIDTH  latched data word
- action_ir  out  IR_WIDTH  latched instruction
- action_valid  out  NUM_CORES  one-cycle strobe per target
- busy  out  1  high while in WAIT
- timeout_err  out  1  sticky: a command was dropped on timeout
- overrun_err  out  1  sticky: a command arrived while busy
- sel_err  out  1  sticky: core_sel was out of range
- cmd_count  out  16  number of issued commands; wraps at 0xFFFF→0

## Operation
- Reset (reset_n=0 at a clk edge) clears every register. All outputs reset to 0. The state returns to IDLE and any pending command is dropped without a strobe.
- Synchroniser: udr_tog passes through S flops, then into a delay flop `d`. udr_pulse = sync[S-1] ^ d.
  - udr_pulse is masked for S+1 cycles after reset release, so no spurious command is taken if the toggle rests at 1.
- IDLE + udr_pulse:
  - core_sel < NUM_CORES or core_sel = BCAST: latch sr→jdo, ir_in→action_ir, target mask (one-hot, or all ones for BCAST). Clear the wait counter. Go to WAIT.
  - Any other core_sel: set sel_err, latch nothing, stay in IDLE.
- WAIT:
  - If (core_ready & mask) == mask: action_valid = mask for exactly one cycle, cmd_count += 1, go to IDLE.
  - Else if TIMEOUT ≠ 0 and the counter = TIMEOUT-1: set timeout_err, no strobe, go to IDLE.
  - Else: counter += 1.
- udr_pulse while in WAIT, and WAIT is not exiting in that cycle: set overrun_err and discard the new command. The pending command is unaffected.
- udr_pulse in the same cycle that WAIT exits (issue or timeout): the new command is accepted as if arriving in IDLE, with no overrun. The state re-enters WAIT, or stays in IDLE with sel_err for a bad select.
- err_clr clears all three error flags. A set in the same cycle wins over err_clr.
- jdo and action_ir hold their values until the next accepted command.

## Timing
- Let edge k be the first clk edge at which sync[0] captures the new udr_tog value.
- udr_pulse is high in the cycle before edge k+S. The command is latched at edge k+S, and busy=1 after that edge.
- If ready is already high, action_valid is high for the single cycle after edge k+S+1, and busy=0 in that same cycle.
- Minimum latency from toggle to strobe is S+2 edges.
- Timeout: with ready never asserted, timeout_err rises after edge k+S+TIMEOUT, and busy falls at the same edge.
- Back-to-back: a second toggle arriving ≥S+2 cycles after the first is never an overrun when targets are ready.
- All outputs are registered. There is no combinational path from an input to an output.

## Test plan
- S=2, core_ready all 1, udr toggle with core_sel=3, ir_in=2, sr=0x2A_1234_5678 → action_valid=0x08 for one cycle, 4 edges after sampling; jdo=0x2A_1234_5678, action_ir=2, cmd_count=1.
- core_sel=BCAST (7), core_ready=0x7E, then bit 0 raised 10 cycles later → no strobe until bit 0 is high; then action_valid=0x7F for one cycle.
- TIMEOUT=16, core_sel=1, core_ready=0 → no strobe; timeout_err=1 exactly 16 cycles after latch; err_clr then clears it.
- Second toggle 1 cycle after the first is latched, target not ready → overrun_err=1; the first command still issues once ready; the second never issues.
- core_sel=5 with NUM_CORES=4 (SEL_W=3) → sel_err=1, busy stays 0; reset asserted mid-WAIT with udr_tog=1 → outputs 0, no strobe, and no spurious command after release.
